// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared hazard-control types and defaults
package pipeline_hazard_controller_pkg;
   localparam int DEFAULT_DIV_LATENCY = 32;
   typedef enum logic {hazardState_run, hazardState_divBusy} HazardState;
   typedef struct packed {
      logic writeEnabled;
      logic flush;
   } StageControl;
   typedef struct packed {
      logic pcWriteEnabled;
      StageControl ifId;
      StageControl idEx;
      StageControl exMem;
   } PipelineControl;
   localparam PipelineControl PIPELINE_ADVANCE = 7'b1_10_10_10;
endpackage

// File: rtl/pipeline_hazard_controller_div_busy_counter.sv
// div_busy_counter: holds EX for a multicycle divide and pulses done on its last cycle
module div_busy_counter
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic abort,
   output logic busy,
   output logic done
);
   localparam int W = $clog2(DIV_LATENCY);
   HazardState state, nextState;
   logic [W-1:0] divCount, nextCount;
   // state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= hazardState_run;
         divCount <= '0;
      end else begin
         state <= nextState;
         divCount <= nextCount;
      end
   end
   // abort wins over start; the start cycle itself is the first stall cycle, hence latency-2
   always_comb begin
      nextState = state;
      nextCount = divCount;
      if (abort) begin
         nextState = hazardState_run;
         nextCount = '0;
      end else if (state == hazardState_run && start) begin
         nextState = hazardState_divBusy;
         nextCount = W'(DIV_LATENCY - 2);
      end else if (state == hazardState_divBusy) begin
         nextState = (divCount == '0) ? hazardState_run : hazardState_divBusy;
         nextCount = (divCount == '0) ? '0 : divCount - W'(1);
      end
   end
   assign busy = (state == hazardState_divBusy);
   assign done = busy && (divCount == '0) && !abort && !reset;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush arbiter for the 5-stage pipeline
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY,
   parameter int COUNTER_WIDTH = 32
) (
   input  logic clock,
   input  logic reset,
   input  logic idStallRequest,
   input  logic exStallRequest,
   input  logic branchTaken,
   input  logic [31:0] branchTarget,
   input  logic divStart,
   input  logic exceptionFlush,
   input  logic [31:0] exceptionVector,
   output logic pcWriteEnabled,
   output logic pcRedirect,
   output logic [31:0] pcRedirectTarget,
   output logic ifIdWriteEnabled,
   output logic idExWriteEnabled,
   output logic exMemWriteEnabled,
   output logic ifIdFlush,
   output logic idExFlush,
   output logic exMemFlush,
   output logic divBusy,
   output logic divDone,
   output logic [COUNTER_WIDTH-1:0] stallCycleCount
);
   PipelineControl ctrl;
   logic pendingValid;
   logic [31:0] pendingTarget;
   logic divHold, idStallOnly, freeCycle;
   div_busy_counter #(.DIV_LATENCY(DIV_LATENCY)) divUnit (
      .clock(clock),
      .reset(reset),
      .start(divStart),
      .abort(exceptionFlush),
      .busy(divBusy),
      .done(divDone)
   );
   assign divHold = divBusy || divStart;
   assign idStallOnly = !reset && !exceptionFlush && !divHold && !exStallRequest && idStallRequest;
   assign freeCycle = !reset && !exceptionFlush && !divHold && !exStallRequest && !idStallRequest;
   // priority arbiter: reset > exception > divide > EX stall > ID stall > redirect
   always_comb begin
      ctrl = PIPELINE_ADVANCE;
      pcRedirect = 1'b0;
      pcRedirectTarget = '0;
      if (reset) begin
         ctrl.ifId.flush = 1'b1;
         ctrl.idEx.flush = 1'b1;
         ctrl.exMem.flush = 1'b1;
      end else if (exceptionFlush) begin
         ctrl.ifId.flush = 1'b1;
         ctrl.idEx.flush = 1'b1;
         ctrl.exMem.flush = 1'b1;
         pcRedirect = 1'b1;
         pcRedirectTarget = exceptionVector;
      end else if (divHold || exStallRequest) begin
         ctrl.pcWriteEnabled = 1'b0;
         ctrl.ifId.writeEnabled = 1'b0;
         ctrl.idEx.writeEnabled = 1'b0;
         ctrl.exMem.flush = 1'b1;
      end else if (idStallRequest) begin
         ctrl.pcWriteEnabled = 1'b0;
         ctrl.ifId.writeEnabled = 1'b0;
         ctrl.idEx.flush = 1'b1;
      end else if (branchTaken || pendingValid) begin
         ctrl.ifId.flush = 1'b1;
         pcRedirect = 1'b1;
         pcRedirectTarget = branchTaken ? branchTarget : pendingTarget;
      end
   end
   assign pcWriteEnabled = ctrl.pcWriteEnabled;
   assign ifIdWriteEnabled = ctrl.ifId.writeEnabled;
   assign idExWriteEnabled = ctrl.idEx.writeEnabled;
   assign exMemWriteEnabled = ctrl.exMem.writeEnabled;
   assign ifIdFlush = ctrl.ifId.flush;
   assign idExFlush = ctrl.idEx.flush;
   assign exMemFlush = ctrl.exMem.flush;
   // a branch resolved under an ID stall is remembered until the first free cycle
   always_ff @(posedge clock) begin
      if (reset || exceptionFlush) begin
         pendingValid <= 1'b0;
         pendingTarget <= '0;
      end else if (idStallOnly && branchTaken) begin
         pendingValid <= 1'b1;
         pendingTarget <= branchTarget;
      end else if (freeCycle) begin
         pendingValid <= 1'b0;
      end
   end
   // counts cycles in which the PC was held
   always_ff @(posedge clock) begin
      if (reset) stallCycleCount <= '0;
      else if (!pcWriteEnabled) stallCycleCount <= stallCycleCount + COUNTER_WIDTH'(1);
   end
endmodule
